// File: rtl/fft_modulus_calc_pkg.sv
// Shared widths, FSM state encoding and output-word layout for fft_modulus_calc.
// Optional frame gating is selected in the top with FFT_MODULUS_FRAME_GATE_EN.
package fft_modulus_pkg;

    localparam int DATA_W_DEF = 31;
    localparam int IDX_W_DEF  = 11;
    localparam int MOD_W_DEF  = 2 * DATA_W_DEF;
    localparam int OUT_W_DEF  = IDX_W_DEF + MOD_W_DEF;

    // Output word is {idx, modulus}: modulus in the low bits, index above it.
    localparam int WORD_MOD_LSB = 0;
    localparam int WORD_IDX_LSB = MOD_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int idx_lsb(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/fft_modulus_calc_if.sv
// Bin stream from the FFT core plus the write side of the downstream modulus FIFO.
// slave = the modulus stage; master = whoever drives bins and models the FIFO.
interface fft_modulus_calc_if #(
    parameter int DATA_W = 31,
    parameter int IDX_W  = 11
);
    localparam int OUT_W = IDX_W + 2 * DATA_W;

    // A bin transfers on a rising edge where fft_valid && fft_ready are both 1;
    // fft_valid never waits on fft_ready, fft_ready may depend on state only.
    logic signed [DATA_W-1:0] fft_re;
    logic signed [DATA_W-1:0] fft_im;
    logic                     fft_valid;
    logic                     fft_last;
    logic                     fft_ready;

    logic [OUT_W-1:0]         wr_data;
    logic                     wr_en;
    logic                     wr_full;
    logic                     almost_full;
    logic [IDX_W:0]           wr_water_level;

    modport slave (
        input  fft_re, fft_im, fft_valid, fft_last,
        input  wr_full, almost_full, wr_water_level,
        output fft_ready, wr_data, wr_en
    );

    modport master (
        output fft_re, fft_im, fft_valid, fft_last,
        output wr_full, almost_full, wr_water_level,
        input  fft_ready, wr_data, wr_en
    );

endinterface

// File: rtl/fft_modulus_calc_sq.sv
// Signed squarer with a single output register; the result is always nonnegative.
module fft_modulus_sq #(
    parameter int DATA_W = 31
) (
    input  logic                     clk,
    input  logic signed [DATA_W-1:0] a_i,
    output logic [2*DATA_W-1:0]      sq_o
);

    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0]        sq_q;

    // Sign-extend first so the most negative input squares to +2^(2*DATA_W-2).
    assign a_ext = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    assign prod  = a_ext * a_ext;

    always_ff @(posedge clk) begin
        sq_q <= prod;
    end

    assign sq_o = sq_q;

endmodule

// File: rtl/fft_modulus_calc.sv
// Squared-magnitude stage: re^2+im^2 in a 3-stage pipeline, tagged with bin index, written to FIFO.
// Define FFT_MODULUS_FRAME_GATE_EN to start a frame only when the FIFO has room for all of it.
module fft_modulus_calc
    import fft_modulus_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int IDX_W      = IDX_W_DEF,
    parameter int FRAME_LEN  = 2 ** IDX_W,
    parameter int FIFO_DEPTH = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    fft_modulus_calc_if.slave    bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 last_err,
    output logic                 ovf_err,
    output state_e               dbg_state_o
);

    localparam int MOD_W   = 2 * DATA_W;
    localparam int OUT_W   = IDX_W + MOD_W;
    localparam int IDX_LSB = idx_lsb(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_err_q, last_err_d;
    logic             frame_done_q, frame_done_d;
    logic             ovf_err_q;

    logic             start_ok;
    logic             run_ready;
    logic             ready;
    logic             accept;
    logic             pipe_empty;

    logic                     s0_v_q;
    logic signed [DATA_W-1:0] s0_re_q;
    logic signed [DATA_W-1:0] s0_im_q;
    logic [IDX_W-1:0]         s0_idx_q;
    logic                     s1_v_q;
    logic [IDX_W-1:0]         s1_idx_q;
    logic [MOD_W-1:0]         re_sq;
    logic [MOD_W-1:0]         im_sq;
    logic                     s2_v_q;
    logic [IDX_W-1:0]         s2_idx_q;
    logic [MOD_W-1:0]         s2_sum_q;
    logic                     wr_en_q;
    logic [OUT_W-1:0]         wr_data_q;

`ifdef FFT_MODULUS_FRAME_GATE_EN
    // A started frame already has FIFO room reserved, so almost_full never throttles it.
    logic unused_af;
    assign unused_af = bus.almost_full;
    assign start_ok  = enable && (int'(bus.wr_water_level) <= (FIFO_DEPTH - FRAME_LEN));
    assign run_ready = 1'b1;
`else
    logic unused_wl;
    assign unused_wl = ^bus.wr_water_level;
    assign start_ok  = enable;
    assign run_ready = !bus.almost_full;
`endif

    assign pipe_empty = !s0_v_q && !s1_v_q && !s2_v_q;
    assign accept     = bus.fft_valid && ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        last_err_d   = last_err_q;
        frame_done_d = 1'b0;
        ready        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (start_ok) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ready = run_ready;
                if (bus.fft_valid && run_ready) begin
                    if (bus.fft_last) begin
                        // An early last still drains normally, resyncing the next frame to idx 0.
                        state_d = ST_DRAIN;
                        idx_d   = '0;
                        if (idx_q != IDX_LAST) begin
                            last_err_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            last_err_d = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            last_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_err_q   <= last_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Valid bits and the output register reset; the data path behind them does not need to.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_v_q    <= 1'b0;
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            ovf_err_q <= 1'b0;
        end else begin
            s0_v_q  <= accept;
            s1_v_q  <= s0_v_q;
            s2_v_q  <= s1_v_q;
            wr_en_q <= s2_v_q && !bus.wr_full;
            if (s2_v_q && bus.wr_full) begin
                ovf_err_q <= 1'b1;
            end
            if (s2_v_q) begin
                wr_data_q[OUT_W-1:IDX_LSB] <= s2_idx_q;
                wr_data_q[IDX_LSB-1:0]     <= s2_sum_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s0_re_q  <= bus.fft_re;
            s0_im_q  <= bus.fft_im;
            s0_idx_q <= idx_q;
        end
        s1_idx_q <= s0_idx_q;
        s2_idx_q <= s1_idx_q;
        // Each square is at most 2^(MOD_W-2), so the sum fits MOD_W bits.
        s2_sum_q <= re_sq + im_sq;
    end

    fft_modulus_sq #(.DATA_W(DATA_W)) u_sq_re (
        .clk  (clk),
        .a_i  (s0_re_q),
        .sq_o (re_sq)
    );

    fft_modulus_sq #(.DATA_W(DATA_W)) u_sq_im (
        .clk  (clk),
        .a_i  (s0_im_q),
        .sq_o (im_sq)
    );

    assign bus.fft_ready = ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_data   = wr_data_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = frame_done_q;
    assign last_err      = last_err_q;
    assign ovf_err       = ovf_err_q;
    assign dbg_state_o   = state_q;

endmodule
